// File: rtl/bridge_tx_hex.sv
// bridge_tx_hex: queues bus read/write completions in a small FIFO and
// serialises each entry as an ASCII hex message on a byte-wide
// ready/valid sink (normally uart_tx).
//   Read entry : PREAMBLE, DATA_WIDTH/4 hex digits (MSB first), CR, LF
//   Write entry: 'W', CR, LF   (only when WRITE_ACK=1; otherwise ignored)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rdata_i       completion data
//   rw_i          0 = read completion, 1 = write completion
//   valid_i       completion strobe, no backpressure
//   ready_i       sink ready
//   data_o        byte to sink (registered)
//   valid_o       byte valid (registered)
//   busy_o        FIFO non-empty or message in flight (registered)
//   overflow_o    sticky flag: an enqueueable completion was dropped
module bridge_tx_hex #(
    parameter int          DATA_WIDTH = 16,
    parameter int          DEPTH      = 4,
    parameter bit          WRITE_ACK  = 1'b0,
    parameter logic [7:0]  PREAMBLE   = 8'h4D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    input  logic                  ready_i,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  overflow_o
);
    localparam int NDIG = DATA_WIDTH / 4;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int IW   = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_DIGIT = 3'd2,
        ST_ACK   = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_e;

    // Entry layout: {rw, data}
    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         count_q, count_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    logic                  enq_s, full_s, push_s, pop_s, xfer_s;
    logic [DATA_WIDTH:0]   head_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = 8'h30 + {4'h0, n};
        end else begin
            r = 8'h37 + {4'h0, n};    // 10 -> 'A' (8'h41)
        end
        return r;
    endfunction

    // Nibble idx counted from the most significant end.
    function automatic logic [3:0] nib_sel(input logic [DATA_WIDTH-1:0] v,
                                           input logic [IW-1:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NDIG; k++) begin
            if (i == IW'(k)) begin
                r = v[(NDIG-1-k)*4 +: 4];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign enq_s  = valid_i && (!rw_i || WRITE_ACK);
    assign full_s = (count_q == CW'(DEPTH));
    assign push_s = enq_s && !full_s;
    assign xfer_s = valid_q && ready_i;
    assign head_s = mem_q[rd_q];

    // Next-state: FIFO bookkeeping, message FSM and registered output values.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        pop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_HEAD: begin
                if (xfer_s) begin
                    state_d = ST_DIGIT;
                    idx_d   = '0;
                end else begin
                    state_d = ST_HEAD;
                end
            end
            ST_DIGIT: begin
                if (xfer_s && (idx_q == IW'(NDIG - 1))) begin
                    state_d = ST_CR;
                end else if (xfer_s) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_ACK: begin
                if (xfer_s) begin
                    state_d = ST_CR;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_CR: begin
                if (xfer_s) begin
                    state_d = ST_LF;
                end else begin
                    state_d = ST_CR;
                end
            end
            ST_LF: begin
                // Chain straight into the next queued entry, no idle bubble.
                if (xfer_s && (count_q != '0)) begin
                    pop_s = 1'b1;
                end else if (xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop_s) begin
            hold_d  = head_s[DATA_WIDTH-1:0];
            idx_d   = '0;
            state_d = head_s[DATA_WIDTH] ? ST_ACK : ST_HEAD;
        end else begin
            hold_d = hold_d;
        end

        wr_d    = push_s ? (wr_q + AW'(1)) : wr_q;
        rd_d    = pop_s  ? (rd_q + AW'(1)) : rd_q;
        count_d = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        ovf_d   = ovf_q || (enq_s && full_s);

        case (state_d)
            ST_HEAD:  data_d = PREAMBLE;
            ST_DIGIT: data_d = hex_ascii(nib_sel(hold_d, idx_d));
            ST_ACK:   data_d = 8'h57;
            ST_CR:    data_d = 8'h0D;
            ST_LF:    data_d = 8'h0A;
            default:  data_d = 8'h00;
        endcase

        valid_d = (state_d != ST_IDLE);
        busy_d  = (count_d != '0) || (state_d != ST_IDLE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_q] <= {rw_i, rdata_i};
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bridge_tx_hex.sv
module tb_bridge_tx_hex;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: default parameters (16-bit, DEPTH 4, no write ack)
    logic [15:0] rdata_a;
    logic        rw_a, valid_a, ready_a;
    logic [7:0]  data_a;
    logic        vo_a, busy_a, ovf_a;

    // DUT B: 32-bit data with write acknowledgements
    logic [31:0] rdata_b;
    logic        rw_b, valid_b, ready_b;
    logic [7:0]  data_b;
    logic        vo_b, busy_b, ovf_b;

    bridge_tx_hex u_a (
        .clk(clk), .rst(rst), .rdata_i(rdata_a), .rw_i(rw_a), .valid_i(valid_a),
        .ready_i(ready_a), .data_o(data_a), .valid_o(vo_a), .busy_o(busy_a),
        .overflow_o(ovf_a)
    );

    bridge_tx_hex #(.DATA_WIDTH(32), .WRITE_ACK(1'b1)) u_b (
        .clk(clk), .rst(rst), .rdata_i(rdata_b), .rw_i(rw_b), .valid_i(valid_b),
        .ready_i(ready_b), .data_o(data_b), .valid_o(vo_b), .busy_o(busy_b),
        .overflow_o(ovf_b)
    );

    int total = 0;
    int bad   = 0;
    int cnt_a = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    // ready_a driver: forced level or pseudo-random
    logic ready_force_a = 1'b1;
    logic rnd_a = 1'b0;
    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ready_a = rnd_a ? 1'($urandom_range(0, 1)) : ready_force_a;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input logic [87:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) q_a.push_back(v[8*i +: 8]);
    endtask

    task automatic exp_b(input logic [87:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) q_b.push_back(v[8*i +: 8]);
    endtask

    task automatic send_a(input logic rw, input logic [15:0] d);
        rdata_a = d; rw_a = rw; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic rw, input logic [31:0] d);
        rdata_b = d; rw_b = rw; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
    endtask

    task automatic drain_a(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (q_a.size() == 0 && !busy_a) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s drain timeout left=%0d busy=%b", name, q_a.size(), busy_a);
        end
    endtask

    task automatic drain_b(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (q_b.size() == 0 && !busy_b) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s drain timeout left=%0d busy=%b", name, q_b.size(), busy_b);
        end
    endtask

    // Monitor A: scoreboard pop on every transfer, plus hold-stability check
    initial begin
        logic       stall;
        logic [7:0] held;
        logic [7:0] e;
        stall = 1'b0; held = 8'h00;
        forever begin
            @(negedge clk);
            if (stall && vo_a) begin
                total++;
                if (data_a !== held) begin
                    bad++;
                    $display("FAIL a_stable got=%h want=%h", data_a, held);
                end
            end
            if (vo_a && ready_a) begin
                total++;
                cnt_a++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("FAIL a_byte got=%h want=none", data_a);
                end else begin
                    e = q_a.pop_front();
                    if (data_a !== e) begin
                        bad++;
                        $display("FAIL a_byte got=%h want=%h", data_a, e);
                    end
                end
            end
            stall = vo_a && !ready_a;
            held  = data_a;
        end
    end

    // Monitor B: ready_b is always high, so only byte order is checked
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (vo_b && ready_b) begin
                total++;
                if (q_b.size() == 0) begin
                    bad++;
                    $display("FAIL b_byte got=%h want=none", data_b);
                end else begin
                    e = q_b.pop_front();
                    if (data_b !== e) begin
                        bad++;
                        $display("FAIL b_byte got=%h want=%h", data_b, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit hit;
        rst = 1'b1;
        rdata_a = 16'h0000; rw_a = 1'b0; valid_a = 1'b0;
        rdata_b = 32'h0;    rw_b = 1'b0; valid_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(vo_a), 32'h0);
        chk("rst_data", 32'(data_a), 32'h00);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);
        tick();

        // 1: read 0x0069, ready high, timing and byte stream
        exp_a(56'h4D_30_30_36_39_0D_0A, 7);
        send_a(1'b0, 16'h0069);
        @(negedge clk);
        chk("t1_lat_idle", 32'(vo_a), 32'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t1_run_valid", 32'(vo_a), 32'h1);
        end
        @(negedge clk);
        chk("t1_end_valid", 32'(vo_a), 32'h0);
        chk("t1_end_busy", 32'(busy_a), 32'h0);
        tick();

        // 2a: write with WRITE_ACK=0 is discarded
        send_a(1'b1, 16'h0042);
        repeat (5) @(negedge clk);
        chk("t2a_valid", 32'(vo_a), 32'h0);
        chk("t2a_busy", 32'(busy_a), 32'h0);
        chk("t2a_ovf", 32'(ovf_a), 32'h0);
        tick();

        // 3: two reads, random ready
        exp_a(56'h4D_42_45_45_46_0D_0A, 7);
        exp_a(56'h4D_31_32_33_34_0D_0A, 7);
        rnd_a = 1'b1;
        send_a(1'b0, 16'hBEEF);
        send_a(1'b0, 16'h1234);
        drain_a("t3");
        rnd_a = 1'b0;
        ready_force_a = 1'b1;
        tick();
        tick();

        // 3b: back-to-back messages with ready high have no gap
        exp_a(56'h4D_31_31_31_31_0D_0A, 7);
        exp_a(56'h4D_32_32_32_32_0D_0A, 7);
        send_a(1'b0, 16'h1111);
        send_a(1'b0, 16'h2222);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("t3b_nogap", 32'(vo_a), 32'h1);
        end
        drain_a("t3b");
        tick();

        // 4: overflow with ready held low
        ready_force_a = 1'b0;
        tick();
        for (int k = 1; k <= 5; k++) begin
            exp_a({8'h4D, 8'h30, 8'h30, 8'h30, 8'h30 + 8'(k), 8'h0D, 8'h0A}, 7);
        end
        for (int k = 1; k <= 5; k++) send_a(1'b0, 16'(k));
        @(negedge clk);
        chk("t4_ovf_before", 32'(ovf_a), 32'h0);
        #1;
        send_a(1'b0, 16'h0006);
        @(negedge clk);
        chk("t4_ovf_after", 32'(ovf_a), 32'h1);
        ready_force_a = 1'b1;
        drain_a("t4");
        chk("t4_ovf_sticky", 32'(ovf_a), 32'h1);
        tick();

        // 6: reset after the third byte with another entry queued
        exp_a(24'h4D_41_42, 3);
        base = cnt_a;
        send_a(1'b0, 16'hABCD);
        send_a(1'b0, 16'h0001);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(posedge clk);
            if (cnt_a - base >= 3) hit = 1'b1;
        end
        chk("t6_third_byte_seen", 32'(hit), 32'h1);
        #1;
        ready_force_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready_force_a = 1'b1;
        @(negedge clk);
        chk("t6_valid", 32'(vo_a), 32'h0);
        chk("t6_busy", 32'(busy_a), 32'h0);
        chk("t6_ovf", 32'(ovf_a), 32'h0);
        repeat (10) @(negedge clk);
        chk("t6_quiet", 32'(vo_a), 32'h0);
        chk("t6_leftover", 32'(q_a.size()), 32'h0);
        tick();
        exp_a(56'h4D_30_30_46_46_0D_0A, 7);
        send_a(1'b0, 16'h00FF);
        drain_a("t6_new");
        tick();

        // 2b and 5 on the 32-bit, write-ack instance
        exp_b(24'h57_0D_0A, 3);
        send_b(1'b1, 32'h0000_0042);
        drain_b("t2b");
        chk("t2b_ovf", 32'(ovf_b), 32'h0);
        tick();
        exp_b(88'h4D_44_45_41_44_42_45_45_46_0D_0A, 11);
        send_b(1'b0, 32'hDEADBEEF);
        drain_b("t5");
        chk("t5_busy", 32'(busy_b), 32'h0);

        chk("end_q_a", 32'(q_a.size()), 32'h0);
        chk("end_q_b", 32'(q_b.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bridge_tx_hex.md
Name: bridge_tx_hex

Overview:
Parametrised successor to the bus-to-UART response encoder. It takes bus read/write completions and queues them in an internal FIFO, so back-to-back completions are never lost. Each queued entry is serialised as an ASCII hex message to a byte-wide ready/valid sink, normally uart_tx. The block sits between the bus core and uart_tx on the host-facing side of the bridge. Relative to the previous encoder it adds configurable data width, queueing, optional write acknowledgements and overflow reporting.

Parameters:
DATA_WIDTH, 16, bus data width; multiple of 4, range 4..64; message carries DATA_WIDTH/4 hex digits.
DEPTH, 4, FIFO entries; power of 2, at least 2.
WRITE_ACK, 0, 1 = writes emit an acknowledge message; 0 = writes are ignored.
PREAMBLE, 8'h4D, first byte of a read response ('M').

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rdata_i  input  DATA_WIDTH  completion data
rw_i  input  1  0 = read completion, 1 = write completion
valid_i  input  1  completion strobe; sampled every clk edge, no backpressure
ready_i  input  1  sink ready
data_o  output  8  byte to sink
valid_o  output  1  byte valid
busy_o  output  1  FIFO non-empty or FSM not IDLE
overflow_o  output  1  sticky: a completion was dropped

Behaviour:
- Reset: valid_o=0, data_o=8'h00, busy_o=0, overflow_o=0. FIFO emptied, FSM goes to IDLE. Reset mid-message aborts the message; no remaining bytes are sent.
- Enqueue: at an edge with valid_i=1, the entry {rw_i, rdata_i} is pushed if it is enqueueable. Enqueueable means rw_i=0, or rw_i=1 with WRITE_ACK=1. With WRITE_ACK=0, writes are silently discarded and do not set overflow.
- Full: judged on the occupancy before the edge. If occupancy==DEPTH, an enqueueable entry is dropped and overflow_o is set, even if a pop happens at the same edge. overflow_o clears only on rst.
- Handshake: a byte transfers at an edge where valid_o && ready_i. While valid_o=1 and ready_i=0, data_o must hold stable. valid_o never deasserts without a transfer, except on rst.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into a holding register. Go to HEAD (read entry) or ACK (write entry). Drive valid_o=1 with the first byte on the next cycle.
  - HEAD: data_o=PREAMBLE. On transfer, go to DIGIT with digit index 0.
  - DIGIT: data_o=hex(nibble), taking nibbles MSB first. On transfer, increment the index; after digit DATA_WIDTH/4-1, go to CR.
  - ACK: data_o=8'h57 ('W'); no data digits. On transfer, go to CR.
  - CR: data_o=8'h0D. On transfer, go to LF.
  - LF: data_o=8'h0A. On transfer, pop the next entry directly if the FIFO is non-empty (no idle bubble). Otherwise go to IDLE and drop valid_o.
- Hex encoding: nibbles 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46 (uppercase).
- Latency: a completion sampled at edge N into an empty, idle block gives valid_o=1 with the first byte after edge N+1. With ready_i held high, one byte transfers per cycle. Message length is DATA_WIDTH/4+3 bytes for reads and 3 bytes for write acks.
- A push and a pop at the same edge leave occupancy unchanged. Pointers wrap modulo DEPTH.
- busy_o is registered and reflects state after each edge.

Test Plan:
1. Defaults, ready_i=1, read rdata_i=16'h0069 -> bytes 4D 30 30 36 39 0D 0A on 7 consecutive cycles, starting 2 cycles after valid_i. valid_o=0 and busy_o=0 afterwards.
2. Write 16'h42, rw_i=1: WRITE_ACK=0 -> no bytes, overflow_o=0. WRITE_ACK=1 -> bytes 57 0D 0A.
3. Reads 16'hBEEF and 16'h1234 on consecutive cycles, ready_i toggled pseudo-randomly -> 4D 42 45 45 46 0D 0A 4D 31 32 33 34 0D 0A. data_o is stable whenever valid_o=1 and ready_i=0, and there is no gap between the two messages when ready_i=1.
4. DEPTH=4, ready_i=0, six reads 1..6 on consecutive cycles -> overflow_o=1 after the sixth. After ready_i=1, only messages for 1..5 are emitted; overflow_o stays 1.
5. DATA_WIDTH=32, read 32'hDEADBEEF -> 4D 44 45 41 44 42 45 45 46 0D 0A (11 bytes).
6. rst asserted for 1 cycle after the third byte of a message with one more entry queued -> valid_o=0 the cycle after rst, no further bytes, busy_o=0, overflow_o=0. A new read afterwards is emitted correctly.
